dogx_cfg_loader: RTL



---
 rtl/dogx_cfg_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dogx_cfg_loader.sv
// DOGX 3-wire config master: frames a latched word with cs_n setup/hold/gap and shifts it MSB-first on sclk.
// Optional auto-resend of the last frame after REFRESH_PERIOD idle cycles when DOGX_AUTO_REFRESH_EN is defined.
module dogx_cfg_loader #(
  parameter int FRAME_BITS     = 72,
  parameter int CLK_DIV        = 4,
  parameter int CS_SETUP       = 2,
  parameter int CS_HOLD        = 2,
  parameter int IDLE_GAP       = 10,
  parameter int REFRESH_PERIOD = 3000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  sdi
);

  localparam int P       = 2 * CLK_DIV;
  localparam int MAX_MUL = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                                                : ((CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP);
  localparam int CW      = $clog2(MAX_MUL * P);
  localparam int BW      = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP * P - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD * P - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP * P - 1);
  localparam logic [CW-1:0] PER_LAST   = CW'(P - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    last;
  logic                    last_bit;
  logic                    load;
  logic [FRAME_BITS-1:0]   load_frame;

`ifdef DOGX_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam logic [RW-1:0] RP_LAST = RW'(REFRESH_PERIOD - 1);

  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic                  armed_q, armed_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic                  refresh;

  // Counter stays inert until a frame has been accepted at least once.
  assign refresh    = (state_q == S_IDLE) && armed_q && (rcnt_q == RP_LAST);
  assign load       = (state_q == S_IDLE) && (start || refresh);
  assign load_frame = start ? frame_in : shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    armed_d  = armed_q;
    rcnt_d   = '0;
    if (state_q == S_IDLE) begin
      if (start) begin
        shadow_d = frame_in;
        armed_d  = 1'b1;
      end else if (armed_q && !refresh) begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q   <= '0;
      armed_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      rcnt_q   <= rcnt_d;
      armed_q  <= armed_d;
      shadow_q <= shadow_d;
    end
  end
`else
  assign load       = (state_q == S_IDLE) && start;
  assign load_frame = frame_in;
`endif

  assign last_bit = (bit_q == BIT_LAST);

  always_comb begin
    last = 1'b0;
    case (state_q)
      S_SETUP: last = (cnt_q == SETUP_LAST);
      S_SHIFT: last = (cnt_q == PER_LAST);
      S_HOLD:  last = (cnt_q == HOLD_LAST);
      S_GAP:   last = (cnt_q == GAP_LAST);
      default: last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SETUP;
      S_SETUP: if (last) state_d = S_SHIFT;
      S_SHIFT: if (last && last_bit) state_d = S_HOLD;
      S_HOLD:  if (last) state_d = S_GAP;
      S_GAP:   if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = (state_q == S_IDLE || last) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (load) begin
        shreg_d = load_frame;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
      end
      S_SHIFT: begin
        // Data advances only on the falling edge between periods, so the LSB stays put into HOLD.
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b1;
        end else if (last) begin
          sclk_d = 1'b0;
          if (last_bit) begin
            bit_d = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      S_HOLD: if (last) begin
        cs_n_d  = 1'b1;
        shreg_d = '0;
      end
      S_GAP: if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdi  = shreg_q[FRAME_BITS-1];
  assign busy = busy_q;
  assign done = done_q;

endmodule
